rv32v_ex_mem_skid_stage: RTL and testbench

- Registered, back-pressurable pipeline stage between the vector execute and vector memory stages.
- Generalises the execute/memory bundle to LANES parallel lanes, each carrying store data, ALU result, write enable and write offset.
- Scalar sideband (vd, eew, vl, vtype, vstart, CSR updates, scalar rd write) travels as one packed struct.
- A 2-entry skid buffer gives full-throughput valid/ready handshaking with registered ready, plus synchronous flush.

---
 rtl/rv32v_types_pkg.sv | 38 +++
 rtl/rv32v_skid_reg.sv | 63 ++++++
 rtl/rv32v_ex_mem_skid_stage.sv | 86 ++++++++
 tb/tb_rv32v_ex_mem_skid_stage.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32v_types_pkg.sv
// Shared types for the vector execute/memory boundary: sideband struct,
// per-lane bundle and skid-buffer state encoding.
package rv32v_types_pkg;

  typedef logic [4:0] offset_t;

  typedef struct packed {
    logic [4:0]  vd;
    logic [2:0]  eew;
    logic [31:0] vl;
    logic [31:0] vtype;
    logic [31:0] next_vtype_csr;
    logic [31:0] next_avl_csr;
    logic [31:0] vstart;
    logic [4:0]  rd_sel;
    logic [31:0] rd_data;
    logic        rd_wen;
    logic [1:0]  config_type;
    logic [2:0]  eew_loadstore;
    logic        single_bit_write;
    logic [7:0]  ls_idx;
  } vexmem_side_t;

  typedef struct packed {
    logic        wen;
    logic [31:0] storedata;
    logic [31:0] aluresult;
    offset_t     woffset;
  } vexmem_lane_t;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    SK_EMPTY = 2'd0,
    SK_ONE   = 2'd1,
    SK_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/rv32v_skid_reg.sv
// Generic 2-entry skid register: main entry M drives the output, skid entry S
// absorbs the beat that arrives while the consumer stalls. in_ready is a state decode.
module rv32v_skid_reg
  import rv32v_types_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   occupancy
);

  skid_state_e  state_q;
  logic [W-1:0] m_q, s_q;
  logic         in_xfer, out_xfer;

  assign in_ready  = (state_q != SK_FULL);
  assign out_valid = (state_q != SK_EMPTY);
  assign out_data  = m_q;
  assign occupancy = state_q;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= SK_EMPTY;
      m_q     <= '0;
      s_q     <= '0;
    end else if (flush) begin
      state_q <= SK_EMPTY;
    end else begin
      unique case (state_q)
        SK_EMPTY: if (in_xfer) begin
          m_q     <= in_data;
          state_q <= SK_ONE;
        end
        SK_ONE: begin
          if (in_xfer && out_xfer) begin
            m_q <= in_data;
          end else if (in_xfer) begin
            s_q     <= in_data;
            state_q <= SK_FULL;
          end else if (out_xfer) begin
            state_q <= SK_EMPTY;
          end
        end
        SK_FULL: if (out_xfer) begin
          m_q     <= s_q;
          state_q <= SK_ONE;
        end
        default: state_q <= SK_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/rv32v_ex_mem_skid_stage.sv
// Back-pressurable EX/MEM stage: packs lanes + sideband into one skid register.
// Optional stall counter under RV32V_EXMEM_STALL_CNT_EN.
module rv32v_ex_mem_skid_stage
  import rv32v_types_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int DATA_W = 32,
  parameter int WOFF_W = 5
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_load_ena,
  input  logic                    in_store_ena,
  input  logic [LANES-1:0]        in_wen,
  input  logic [LANES*DATA_W-1:0] in_storedata,
  input  logic [LANES*DATA_W-1:0] in_aluresult,
  input  logic [LANES*WOFF_W-1:0] in_woffset,
  input  vexmem_side_t            in_side,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_load_ena,
  output logic                    out_store_ena,
  output logic [LANES-1:0]        out_wen,
  output logic [LANES*DATA_W-1:0] out_storedata,
  output logic [LANES*DATA_W-1:0] out_aluresult,
  output logic [LANES*WOFF_W-1:0] out_woffset,
  output vexmem_side_t            out_side,
  output logic [1:0]              occupancy
`ifdef RV32V_EXMEM_STALL_CNT_EN
  ,
  output logic [31:0]             stall_cycles
`endif
);

  localparam int PW = 2 + LANES * (1 + 2 * DATA_W + WOFF_W) + $bits(vexmem_side_t);

  logic [PW-1:0]    pl_in, pl_out;
  logic             ld_raw, st_raw;
  logic [LANES-1:0] wen_raw;
  vexmem_side_t     side_raw;

  assign pl_in = {in_load_ena, in_store_ena, in_wen, in_storedata, in_aluresult,
                  in_woffset, in_side};

  rv32v_skid_reg #(.W(PW)) u_skid (
    .CLK       (CLK),
    .RST       (RST),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (pl_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (pl_out),
    .occupancy (occupancy)
  );

  assign {ld_raw, st_raw, wen_raw, out_storedata, out_aluresult, out_woffset, side_raw} = pl_out;

  // Side-effecting enables must never leak from a stale entry.
  assign out_load_ena  = ld_raw & out_valid;
  assign out_store_ena = st_raw & out_valid;
  assign out_wen       = wen_raw & {LANES{out_valid}};

  always_comb begin
    out_side        = side_raw;
    out_side.rd_wen = side_raw.rd_wen & out_valid;
  end

`ifdef RV32V_EXMEM_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge CLK) begin
    if (RST)
      stall_q <= '0;
    else if (out_valid && !out_ready && (stall_q != 32'hFFFF_FFFF))
      stall_q <= stall_q + 32'd1;
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_rv32v_ex_mem_skid_stage.sv
// Directed bench for rv32v_ex_mem_skid_stage: default build plus a 4-lane 64-bit build.
// Stall counter checks follow RV32V_EXMEM_STALL_CNT_EN.
module tb_rv32v_ex_mem_skid_stage;
  import rv32v_types_pkg::*;

  logic CLK = 1'b0, RST, flush, in_valid, out_ready;
  logic in_load_ena, in_store_ena;
  logic [1:0]  in_wen;
  logic [63:0] in_storedata, in_aluresult;
  logic [9:0]  in_woffset;
  vexmem_side_t in_side, out_side, wo_side;
  logic        in_ready, out_valid, out_load_ena, out_store_ena;
  logic [1:0]  out_wen, occupancy;
  logic [63:0] out_storedata, out_aluresult;
  logic [9:0]  out_woffset;

  logic [3:0]   w_wen, wo_wen;
  logic [255:0] w_storedata, w_aluresult, wo_storedata, wo_aluresult;
  logic [19:0]  w_woffset, wo_woffset;
  logic         wo_in_ready, wo_valid, wo_load_ena, wo_store_ena;
  logic [1:0]   wo_occ;
`ifdef RV32V_EXMEM_STALL_CNT_EN
  logic [31:0] stall_cycles, wo_stall;
`endif

  int n_cmp = 0, n_err = 0;

  always #5 CLK = ~CLK;

  rv32v_ex_mem_skid_stage dut (
    .CLK(CLK), .RST(RST), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_load_ena(in_load_ena), .in_store_ena(in_store_ena), .in_wen(in_wen),
    .in_storedata(in_storedata), .in_aluresult(in_aluresult), .in_woffset(in_woffset),
    .in_side(in_side), .out_valid(out_valid), .out_ready(out_ready),
    .out_load_ena(out_load_ena), .out_store_ena(out_store_ena), .out_wen(out_wen),
    .out_storedata(out_storedata), .out_aluresult(out_aluresult),
    .out_woffset(out_woffset), .out_side(out_side), .occupancy(occupancy)
`ifdef RV32V_EXMEM_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  rv32v_ex_mem_skid_stage #(.LANES(4), .DATA_W(64), .WOFF_W(5)) u_wide (
    .CLK(CLK), .RST(RST), .flush(flush), .in_valid(in_valid), .in_ready(wo_in_ready),
    .in_load_ena(in_load_ena), .in_store_ena(in_store_ena), .in_wen(w_wen),
    .in_storedata(w_storedata), .in_aluresult(w_aluresult), .in_woffset(w_woffset),
    .in_side(in_side), .out_valid(wo_valid), .out_ready(out_ready),
    .out_load_ena(wo_load_ena), .out_store_ena(wo_store_ena), .out_wen(wo_wen),
    .out_storedata(wo_storedata), .out_aluresult(wo_aluresult),
    .out_woffset(wo_woffset), .out_side(wo_side), .occupancy(wo_occ)
`ifdef RV32V_EXMEM_STALL_CNT_EN
    , .stall_cycles(wo_stall)
`endif
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [31:0] v);
    in_valid     = 1'b1;
    in_aluresult = {32'h0, v};
    in_wen       = 2'b11;
  endtask

  task automatic test_reset();
    RST = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_load_ena = 1'b0; in_store_ena = 1'b0; in_wen = '0;
    in_storedata = '0; in_aluresult = '0; in_woffset = '0; in_side = '0;
    w_wen = '0; w_storedata = '0; w_aluresult = '0; w_woffset = '0;
    step(); step();
    RST = 1'b0;
    step();
    if (in_ready !== 1'b1) begin $display("FAIL reset_in_ready got %b exp 1", in_ready); n_err++; end
    n_cmp++;
    if (out_valid !== 1'b0) begin $display("FAIL reset_out_valid got %b exp 0", out_valid); n_err++; end
    n_cmp++;
    if (occupancy !== 2'd0) begin $display("FAIL reset_occ got %0d exp 0", occupancy); n_err++; end
    n_cmp++;
    if (out_aluresult !== 64'h0) begin $display("FAIL reset_alu got %h exp 0", out_aluresult); n_err++; end
    n_cmp++;
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      push(32'h100 + k);
      step();
      if (out_valid !== 1'b1 || out_aluresult[31:0] !== 32'h100 + k) begin
        $display("FAIL stream_beat%0d got v=%b %h exp v=1 %h", k, out_valid, out_aluresult[31:0], 32'h100 + k);
        n_err++;
      end
      n_cmp++;
      if (in_ready !== 1'b1 || occupancy !== 2'd1) begin
        $display("FAIL stream_flow%0d got rdy=%b occ=%0d exp rdy=1 occ=1", k, in_ready, occupancy);
        n_err++;
      end
      n_cmp++;
    end
    in_valid = 1'b0;
    step();
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_wen !== 2'b00) begin
      $display("FAIL stream_drain got occ=%0d v=%b wen=%b exp 0 0 00", occupancy, out_valid, out_wen);
      n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    push(32'hA); step();
    push(32'hB); step();
    if (in_ready !== 1'b0 || occupancy !== 2'd2) begin
      $display("FAIL bp_full got rdy=%b occ=%0d exp rdy=0 occ=2", in_ready, occupancy); n_err++;
    end
    n_cmp++;
    push(32'hC); step();
    if (occupancy !== 2'd2 || out_aluresult[31:0] !== 32'hA) begin
      $display("FAIL bp_hold got occ=%0d out=%h exp occ=2 out=a", occupancy, out_aluresult[31:0]); n_err++;
    end
    n_cmp++;
    out_ready = 1'b1; step();
    if (out_aluresult[31:0] !== 32'hB || occupancy !== 2'd1) begin
      $display("FAIL bp_second got out=%h occ=%0d exp out=b occ=1", out_aluresult[31:0], occupancy); n_err++;
    end
    n_cmp++;
    step();
    if (out_aluresult[31:0] !== 32'hC || occupancy !== 2'd1) begin
      $display("FAIL bp_third got out=%h occ=%0d exp out=c occ=1", out_aluresult[31:0], occupancy); n_err++;
    end
    n_cmp++;
    in_valid = 1'b0; step();
    if (occupancy !== 2'd0) begin $display("FAIL bp_empty got occ=%0d exp 0", occupancy); n_err++; end
    n_cmp++;
  endtask

  task automatic test_simultaneous();
    out_ready = 1'b0;
    push(32'hAA); step();
    push(32'hBB); out_ready = 1'b1; step();
    if (out_aluresult[31:0] !== 32'hBB || occupancy !== 2'd1) begin
      $display("FAIL simul got out=%h occ=%0d exp out=bb occ=1", out_aluresult[31:0], occupancy); n_err++;
    end
    n_cmp++;
    in_valid = 1'b0; step();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    push(32'h1); step();
    push(32'h2); step();
    push(32'h3); flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    if (out_valid !== 1'b0 || out_wen !== 2'b00 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
      $display("FAIL flush got v=%b wen=%b occ=%0d rdy=%b exp 0 00 0 1", out_valid, out_wen, occupancy, in_ready);
      n_err++;
    end
    n_cmp++;
    out_ready = 1'b1; step(); step();
    if (out_valid !== 1'b0) begin $display("FAIL flush_ghost got v=%b exp 0", out_valid); n_err++; end
    n_cmp++;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    push(32'h5); step();
    push(32'h6); step();
    in_valid = 1'b0; RST = 1'b1; step();
    RST = 1'b0;
    if (out_aluresult !== 64'h0 || in_ready !== 1'b1 || occupancy !== 2'd0 || out_valid !== 1'b0) begin
      $display("FAIL rst_mid got alu=%h rdy=%b occ=%0d v=%b exp 0 1 0 0", out_aluresult, in_ready, occupancy, out_valid);
      n_err++;
    end
    n_cmp++;
    out_ready = 1'b1; push(32'h7); step();
    if (out_valid !== 1'b1 || out_aluresult[31:0] !== 32'h7) begin
      $display("FAIL rst_mid_next got v=%b out=%h exp v=1 7", out_valid, out_aluresult[31:0]); n_err++;
    end
    n_cmp++;
    in_valid = 1'b0; step();
  endtask

  task automatic test_wide_side();
    out_ready = 1'b1;
    w_storedata = '0;
    w_storedata[3*64 +: 64] = 64'hDEADBEEF_CAFEF00D;
    w_woffset = '0;
    w_woffset[3*5 +: 5] = 5'd31;
    w_wen = 4'b1000;
    in_side = '0; in_side.rd_wen = 1'b1; in_side.rd_data = 32'h1234_5678; in_side.vd = 5'd9;
    in_load_ena = 1'b1;
    push(32'h55); step();
    if (wo_storedata[3*64 +: 64] !== 64'hDEADBEEF_CAFEF00D || wo_woffset[3*5 +: 5] !== 5'd31) begin
      $display("FAIL wide_lane3 got sd=%h wo=%0d exp deadbeefcafef00d 31", wo_storedata[3*64 +: 64], wo_woffset[3*5 +: 5]);
      n_err++;
    end
    n_cmp++;
    if (wo_storedata[63:0] !== 64'h0 || wo_wen !== 4'b1000) begin
      $display("FAIL wide_lane0 got sd=%h wen=%b exp 0 1000", wo_storedata[63:0], wo_wen); n_err++;
    end
    n_cmp++;
    if (out_side.rd_data !== 32'h1234_5678 || out_side.rd_wen !== 1'b1 || out_side.vd !== 5'd9 || out_load_ena !== 1'b1) begin
      $display("FAIL side_pass got rd=%h wen=%b vd=%0d ld=%b exp 12345678 1 9 1", out_side.rd_data, out_side.rd_wen, out_side.vd, out_load_ena);
      n_err++;
    end
    n_cmp++;
    in_valid = 1'b0; step();
    if (out_side.rd_wen !== 1'b0 || out_load_ena !== 1'b0 || wo_wen !== 4'b0000) begin
      $display("FAIL side_mask got rdwen=%b ld=%b wwen=%b exp 0 0 0000", out_side.rd_wen, out_load_ena, wo_wen); n_err++;
    end
    n_cmp++;
    in_load_ena = 1'b0; in_side = '0;
  endtask

`ifdef RV32V_EXMEM_STALL_CNT_EN
  task automatic test_stall_cnt();
    RST = 1'b1; in_valid = 1'b0; step(); RST = 1'b0;
    out_ready = 1'b0;
    push(32'h9); step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    if (stall_cycles !== 32'd5 || wo_stall !== 32'd5) begin
      $display("FAIL stall_five got %0d/%0d exp 5", stall_cycles, wo_stall); n_err++;
    end
    n_cmp++;
    flush = 1'b1; step(); flush = 1'b0; step();
    if (stall_cycles !== 32'd6) begin $display("FAIL stall_flush got %0d exp 6", stall_cycles); n_err++; end
    n_cmp++;
  endtask
`endif

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_simultaneous();
    test_flush();
    test_reset_mid();
    test_wide_side();
`ifdef RV32V_EXMEM_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
